count_seq_monitor: RTL and testbench
====================================

Name: count_seq_monitor

Overview:
- Downstream consumer of the 3-bit T-flip-flop up/down counter.
- Samples the counter's `out` and mode `m` every `clk` edge and checks that each step is exactly +1 (m=0) or -1 (m=1) modulo 2^WIDTH.
- Reports lock, step faults, terminal-count pulses and a wrap tally to the display/status logic downstream.

Parameters:
- WIDTH, 3: width of the monitored count.
- LOCK_STEPS, 2: consecutive legal steps needed before `locked` asserts; legal range 1..15.
- WRAP_W, 8: width of the wrap counter.

Ports:
- clk  input  1  single system clock; the same clk that drives the counter.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- m  input  1  direction input, wired to the counter's mode; 0 = up, 1 = down.
- cnt  input  WIDTH  counter output.
- clr_fault  input  1  synchronous request to leave FAULT.
- locked  output  1  high while in LOCKED.
- fault  output  1  high while in FAULT.
- tc  output  1  one-cycle pulse on a legal wrap (7->0 up or 0->7 down).
- wraps  output  WRAP_W  count of legal wraps; increments with tc; rolls over.
- last_bad  output  WIDTH  cnt value that caused the most recent fault.

Behaviour:
- Everything is clocked on the rising edge of clk. rst is sampled on that edge (synchronous); there is no asynchronous path.
- Reset values: state=IDLE, locked=0, fault=0, tc=0, wraps=0, last_bad=0, prev_cnt=0, prev_m=0, good=0.
- Internal registers: prev_cnt and prev_m hold the previous cycle's cnt and m. The step check uses prev_m, because the counter's step at edge k is governed by m at edge k-1.
- Expected value: exp = prev_cnt+1 if prev_m=0, else prev_cnt-1. Arithmetic is WIDTH bits, so it wraps naturally.
- A step is legal when cnt == exp.
- States:
  - IDLE: capture cnt/m and go to ACQUIRE; good=0; no check is performed.
  - ACQUIRE:
    - Legal step: good++. Move to LOCKED on the edge where good reaches LOCK_STEPS.
    - Illegal step: good=0, stay in ACQUIRE. No fault is raised while unlocked.
  - LOCKED:
    - Legal step: stay.
    - Illegal step: go to FAULT and capture last_bad=cnt.
  - FAULT:
    - clr_fault=1: go to ACQUIRE with good=0.
    - Otherwise stay. Further bad steps do not update last_bad.
- prev_cnt and prev_m update every non-reset cycle in every state.
- Outputs are registered; locked and fault follow the state on the same edge as the transition.
- tc: asserted for exactly one cycle after a legal wrap step, in ACQUIRE or LOCKED only.
  - Up wrap: prev_m=0, prev_cnt=2^WIDTH-1, cnt=0.
  - Down wrap: prev_m=1, prev_cnt=0, cnt=2^WIDTH-1.
  - wraps increments on the same edge that tc asserts; WRAP_W-bit rollover.
- Direction change (m toggles): legal. The next step is checked against the new prev_m, with no lock loss.
- Simultaneous illegal step and clr_fault while in FAULT: clr_fault wins; go to ACQUIRE.
- rst mid-operation: all state returns to reset values on that edge. The first post-reset cycle is IDLE, so no false fault is possible.
- The 1-cycle IDLE capture means `locked` rises at the earliest LOCK_STEPS+1 cycles after rst deasserts.

Optional Feature:
- Macro: HOLD_ALLOW_EN.
- Defined: cnt == prev_cnt is a legal "hold" step, used when the counter clock is gated.
  - A hold does not increment good or assert tc, and does not cause a fault in LOCKED.
- Undefined: a hold is an illegal step, like any other mismatch.

Test Plan:
- Reset then up-count: rst=1 for 2 cycles, then m=0, cnt 0,1,2,...,7,0,1 -> locked=1 on the 3rd cycle after rst falls; tc=1 one cycle after cnt 7->0; wraps=1.
- Down-count with wrap: m=1, cnt 2,1,0,7,6 -> locked asserts; tc pulses once after the 0->7 step; fault stays 0.
- Direction change: up 3,4,5 with m=0, then m=1 sampled with cnt=5, next cnt=4 -> no fault; locked stays 1.
- Injected glitch: while locked, m=0, cnt 4 then 6 -> fault=1, locked=0, last_bad=6. A further bad value 1 leaves last_bad=6. Pulsing clr_fault -> ACQUIRE; relock after 2 legal steps.
- Hold step: locked, m=0, cnt 5,5.
  - Without HOLD_ALLOW_EN: fault=1, last_bad=5.
  - With HOLD_ALLOW_EN: fault=0, locked=1, wraps unchanged.
- Reset mid-operation: locked with wraps=3, assert rst for 1 cycle -> wraps=0, locked=0, fault=0, tc=0. The next step from an arbitrary cnt causes no fault.

Source files
------------

// File: rtl/count_seq_monitor.sv
// Step monitor for an up/down counter: checks every cnt step is +/-1 under the previous mode.
// Optional HOLD_ALLOW_EN macro: cnt == prev_cnt is accepted as a legal "hold" step.
module count_seq_monitor #(
  parameter int WIDTH      = 3,
  parameter int LOCK_STEPS = 2,
  parameter int WRAP_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m,
  input  logic [WIDTH-1:0]  cnt,
  input  logic              clr_fault,
  output logic              locked,
  output logic              fault,
  output logic              tc,
  output logic [WRAP_W-1:0] wraps,
  output logic [WIDTH-1:0]  last_bad,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_STEPS);

  state_t           state_q, state_d;
  logic [3:0]       good_q, good_d, good_inc;
  logic [WIDTH-1:0] prev_cnt, exp_cnt;
  logic             prev_m;
  logic             step_ok, hold_ok, wrap_step;
  logic             tc_d, capture_bad;

  // The counter's step at this edge was governed by m one edge earlier.
  assign exp_cnt   = prev_m ? (prev_cnt - WIDTH'(1)) : (prev_cnt + WIDTH'(1));
  assign step_ok   = (cnt == exp_cnt);
  assign wrap_step = step_ok && (prev_m ? (prev_cnt == '0) : (prev_cnt == {WIDTH{1'b1}}));

`ifdef HOLD_ALLOW_EN
  assign hold_ok = (cnt == prev_cnt);
`else
  assign hold_ok = 1'b0;
`endif

  assign good_inc  = good_q + 4'd1;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    tc_d        = 1'b0;
    capture_bad = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = ACQUIRE;
        good_d  = '0;
      end
      ACQUIRE: begin
        if (step_ok) begin
          good_d = good_inc;
          tc_d   = wrap_step;
          if (good_inc >= LOCK_CNT) state_d = LOCKED;
        end else if (!hold_ok) begin
          good_d = '0;
        end
      end
      LOCKED: begin
        if (step_ok) begin
          tc_d = wrap_step;
        end else if (!hold_ok) begin
          state_d     = FAULT;
          capture_bad = 1'b1;
        end
      end
      FAULT: begin
        // clr_fault takes priority over whatever the current step looks like.
        if (clr_fault) begin
          state_d = ACQUIRE;
          good_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      good_q   <= '0;
      prev_cnt <= '0;
      prev_m   <= 1'b0;
      locked   <= 1'b0;
      fault    <= 1'b0;
      tc       <= 1'b0;
      wraps    <= '0;
      last_bad <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      prev_cnt <= cnt;
      prev_m   <= m;
      locked   <= (state_d == LOCKED);
      fault    <= (state_d == FAULT);
      tc       <= tc_d;
      if (tc_d) wraps <= wraps + WRAP_W'(1);
      if (capture_bad) last_bad <= cnt;
    end
  end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor; expected outputs are queued per step and checked after the edge.
// Hold-step expectations switch on HOLD_ALLOW_EN.
module tb_count_seq_monitor;

  localparam int WIDTH  = 3;
  localparam int WRAP_W = 8;
  localparam int OW     = 3 + WRAP_W + WIDTH;

`ifdef HOLD_ALLOW_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m = 1'b0;
  logic [WIDTH-1:0]  cnt = '0;
  logic              clr_fault = 1'b0;
  logic              locked, fault, tc;
  logic [WRAP_W-1:0] wraps;
  logic [WIDTH-1:0]  last_bad;
  logic [1:0]        dbg_state;

  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  count_seq_monitor #(.WIDTH(WIDTH), .LOCK_STEPS(2), .WRAP_W(WRAP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .m         (m),
    .cnt       (cnt),
    .clr_fault (clr_fault),
    .locked    (locked),
    .fault     (fault),
    .tc        (tc),
    .wraps     (wraps),
    .last_bad  (last_bad),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the expected registered outputs, check them after the edge.
  task automatic step(input string tag, input logic r, input logic mm, input int c, input logic clr,
                      input logic el, input logic ef, input logic et, input int ew, input int eb);
    logic [OW-1:0] e;
    logic [OW-1:0] obs;
    @(negedge clk);
    rst       = r;
    m         = mm;
    cnt       = WIDTH'(c);
    clr_fault = clr;
    exp_q.push_back({el, ef, et, WRAP_W'(ew), WIDTH'(eb)});
    @(posedge clk);
    #1;
    e   = exp_q.pop_front();
    obs = {locked, fault, tc, wraps, last_bad};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed locked=%b fault=%b tc=%b wraps=%0d last_bad=%0d, expected locked=%b fault=%b tc=%b wraps=%0d last_bad=%0d",
             tag, obs[OW-1], obs[OW-2], obs[OW-3], obs[WIDTH +: WRAP_W], obs[WIDTH-1:0],
             e[OW-1], e[OW-2], e[OW-3], e[WIDTH +: WRAP_W], e[WIDTH-1:0]);
    end
  endtask

  initial begin
    int lbh;
    lbh = HOLD_ON ? 6 : 5;

    // Reset for two cycles, then count up through a wrap.
    step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      step("up", 0, 0, i % 8, 0, (i >= 2), 0, (i == 8), (i >= 8) ? 1 : 0, 0);

    // Fresh reset, then count down through 0 -> 7.
    step("dn_rst", 1, 1, 3, 0, 0, 0, 0, 0, 0);
    step("dn_idle", 0, 1, 2, 0, 0, 0, 0, 0, 0);
    step("dn_g1",   0, 1, 1, 0, 0, 0, 0, 0, 0);
    step("dn_lock", 0, 1, 0, 0, 1, 0, 0, 0, 0);
    step("dn_wrap", 0, 1, 7, 0, 1, 0, 1, 1, 0);
    step("dn_post", 0, 1, 6, 0, 1, 0, 0, 1, 0);

    // Direction changes while locked: never a fault.
    step("dir_a", 0, 1, 5, 0, 1, 0, 0, 1, 0);
    step("dir_b", 0, 1, 4, 0, 1, 0, 0, 1, 0);
    step("dir_c", 0, 0, 3, 0, 1, 0, 0, 1, 0);
    step("dir_d", 0, 0, 4, 0, 1, 0, 0, 1, 0);
    step("dir_e", 0, 1, 5, 0, 1, 0, 0, 1, 0);
    step("dir_f", 0, 1, 4, 0, 1, 0, 0, 1, 0);

    // Glitch 4 -> 6 while locked, sticky last_bad, clr_fault beats a bad step, relock.
    step("gl_a",     0, 0, 3, 0, 1, 0, 0, 1, 0);
    step("gl_b",     0, 0, 4, 0, 1, 0, 0, 1, 0);
    step("gl_bad",   0, 0, 6, 0, 0, 1, 0, 1, 6);
    step("gl_bad2",  0, 0, 1, 0, 0, 1, 0, 1, 6);
    step("gl_clr",   0, 0, 5, 1, 0, 0, 0, 1, 6);
    step("acq_g1",   0, 0, 6, 0, 0, 0, 0, 1, 6);
    step("acq_bad",  0, 0, 0, 0, 0, 0, 0, 1, 6);
    step("acq_g1b",  0, 0, 1, 0, 0, 0, 0, 1, 6);
    step("acq_lock", 0, 0, 2, 0, 1, 0, 0, 1, 6);

    // Hold step 5,5 while locked.
    step("hd_a",    0, 0, 3, 0, 1, 0, 0, 1, 6);
    step("hd_b",    0, 0, 4, 0, 1, 0, 0, 1, 6);
    step("hd_c",    0, 0, 5, 0, 1, 0, 0, 1, 6);
    step("hd_hold", 0, 0, 5, 0, HOLD_ON, !HOLD_ON, 0, 1, lbh);
    step("hd_clr",  0, 0, 6, 1, HOLD_ON, 0, 0, 1, lbh);
    step("hd_next", 0, 0, 7, 0, HOLD_ON, 0, 0, 1, lbh);
    step("hd_wrap", 0, 0, 0, 0, 1, 0, 1, 2, lbh);

    // Third wrap, then reset mid-operation and restart from an arbitrary count.
    step("mr_a",    0, 1, 1, 0, 1, 0, 0, 2, lbh);
    step("mr_b",    0, 1, 0, 0, 1, 0, 0, 2, lbh);
    step("mr_wrap", 0, 1, 7, 0, 1, 0, 1, 3, lbh);
    step("mr_c",    0, 1, 6, 0, 1, 0, 0, 3, lbh);
    step("mr_rst",  1, 1, 6, 0, 0, 0, 0, 0, 0);
    step("mr_idle", 0, 0, 5, 0, 0, 0, 0, 0, 0);
    step("mr_bad",  0, 0, 2, 0, 0, 0, 0, 0, 0);
    step("mr_g1",   0, 0, 3, 0, 0, 0, 0, 0, 0);
    step("mr_lock", 0, 0, 4, 0, 1, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
